// File: rtl/platform_scroll_sched.sv
// Per-frame platform scroller: shifts the 15-slot table down by the doodle's overshoot above the
// scroll line, recycles wrapped slots to a pseudo-random X, and keeps a saturating height score.
module platform_scroll_sched #(
    parameter int          NUM_PLAT    = 15,
    parameter int          SCREEN_H    = 480,
    parameter int          SCROLL_LINE = 200,
    parameter int          MAX_SCROLL  = 15,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  doodle_y,
    input  logic [3:0]  rd_idx,
    output logic [9:0]  rd_x,
    output logic [9:0]  rd_y,
    output logic [3:0]  scroll_dy,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] score,
    output logic        overrun
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [10:0] SCREEN_H_W    = 11'(SCREEN_H);
    localparam logic [9:0]  SCROLL_LINE_W = 10'(SCROLL_LINE);
    localparam logic [9:0]  MAX_SCROLL_W  = 10'(MAX_SCROLL);
    localparam logic [3:0]  LAST_IDX      = 4'(NUM_PLAT - 1);
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        sync_prev_q, sync_prev_d;
    logic [1:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  dy_q, dy_d;
    logic [15:0] score_q, score_d;
    logic        overrun_q, overrun_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [9:0]  x_q [NUM_PLAT];
    logic [9:0]  x_d [NUM_PLAT];
    logic [9:0]  y_q [NUM_PLAT];
    logic [9:0]  y_d [NUM_PLAT];
    logic [9:0]  rd_x_q, rd_x_d;
    logic [9:0]  rd_y_q, rd_y_d;

    logic        trig;
    logic [9:0]  diff;
    logic [3:0]  dy_calc;
    logic [10:0] ny;
    logic [10:0] ny_wrap;
    logic [16:0] score_sum;
    logic [3:0]  rd_sel;
    logic [15:0] lfsr_next;

    assign trig      = sync2_q & ~sync_prev_q;
    assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    always_comb begin
        sync1_d     = frame_clk;
        sync2_d     = sync1_q;
        sync_prev_d = sync2_q;
        state_d     = state_q;
        idx_d       = idx_q;
        dy_d        = dy_q;
        score_d     = score_q;
        overrun_d   = overrun_q;
        lfsr_d      = lfsr_q;
        x_d         = x_q;
        y_d         = y_q;
        diff        = SCROLL_LINE_W - doodle_y;
        dy_calc     = 4'd0;
        ny          = {1'b0, y_q[idx_q]} + {7'd0, dy_q};
        ny_wrap     = ny - SCREEN_H_W;
        score_sum   = {1'b0, score_q} + {13'd0, dy_q};

        // A trigger during a running sequence is dropped but remembered.
        if (trig && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        if (doodle_y < SCROLL_LINE_W) begin
            dy_calc = (diff > MAX_SCROLL_W) ? MAX_SCROLL_W[3:0] : diff[3:0];
        end

        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                dy_d    = dy_calc;
                idx_d   = 4'd0;
                state_d = (dy_calc != 4'd0) ? S_UPDATE : S_DONE;
            end
            S_UPDATE: begin
                if (ny >= SCREEN_H_W) begin
                    y_d[idx_q] = ny_wrap[9:0];
                    x_d[idx_q] = {1'b0, lfsr_q[8:0]};
                    lfsr_d     = lfsr_next;
                end else begin
                    y_d[idx_q] = ny[9:0];
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: begin
                score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                state_d = S_IDLE;
            end
        endcase
    end

    // Out-of-range render reads return zeros without indexing past the table.
    always_comb begin
        rd_sel = (rd_idx < 4'(NUM_PLAT)) ? rd_idx : 4'd0;
        rd_x_d = 10'd0;
        rd_y_d = 10'd0;
        if (rd_idx < 4'(NUM_PLAT)) begin
            rd_x_d = x_q[rd_sel];
            rd_y_d = y_q[rd_sel];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync_prev_q <= 1'b0;
            state_q     <= S_IDLE;
            idx_q       <= 4'd0;
            dy_q        <= 4'd0;
            score_q     <= 16'd0;
            overrun_q   <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            rd_x_q      <= 10'd0;
            rd_y_q      <= 10'd0;
            for (int i = 0; i < NUM_PLAT; i++) begin
                x_q[i] <= 10'(64 + 32 * i);
                y_q[i] <= 10'(32 * i);
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync_prev_q <= sync_prev_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            dy_q        <= dy_d;
            score_q     <= score_d;
            overrun_q   <= overrun_d;
            lfsr_q      <= lfsr_d;
            rd_x_q      <= rd_x_d;
            rd_y_q      <= rd_y_d;
            for (int i = 0; i < NUM_PLAT; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    assign rd_x       = rd_x_q;
    assign rd_y       = rd_y_q;
    assign scroll_dy  = dy_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);
    assign score      = score_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_platform_scroll_sched.sv
// Directed bench for platform_scroll_sched with a behavioural table/LFSR/score reference.
module tb_platform_scroll_sched;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [9:0]  doodle_y = 10'd300;
    logic [3:0]  rd_idx = 4'd0;
    logic [9:0]  rd_x;
    logic [9:0]  rd_y;
    logic [3:0]  scroll_dy;
    logic        busy;
    logic        frame_done;
    logic [15:0] score;
    logic        overrun;

    int checks = 0;
    int failures = 0;

    int          mx [15];
    int          my [15];
    logic [15:0] m_lfsr;
    int          m_score;

    platform_scroll_sched dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .doodle_y   (doodle_y),
        .rd_idx     (rd_idx),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .scroll_dy  (scroll_dy),
        .busy       (busy),
        .frame_done (frame_done),
        .score      (score),
        .overrun    (overrun)
    );

    always #5 Clk = ~Clk;

    task automatic model_reset();
        for (int i = 0; i < 15; i++) begin
            mx[i] = 64 + 32 * i;
            my[i] = 32 * i;
        end
        m_lfsr  = 16'hACE1;
        m_score = 0;
    endtask

    function automatic int dy_of(input int d);
        if (d >= 200) return 0;
        if (200 - d > 15) return 15;
        return 200 - d;
    endfunction

    task automatic model_frame(input int dy);
        for (int i = 0; i < 15; i++) begin
            if (my[i] + dy >= 480) begin
                my[i]  = my[i] + dy - 480;
                mx[i]  = int'(m_lfsr) % 512;
                m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
            end else begin
                my[i] = my[i] + dy;
            end
        end
        m_score = (m_score + dy > 65535) ? 65535 : m_score + dy;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        frame_clk = 1'b0;
        rd_idx = 4'd0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic read_slot(input int i, output int x, output int y);
        rd_idx = 4'(i);
        @(negedge Clk);
        x = int'(rd_x);
        y = int'(rd_y);
    endtask

    task automatic run_frame(input int dd, output int bc, output int fc);
        doodle_y = 10'(dd);
        frame_clk = 1'b1;
        bc = 0;
        fc = 0;
        repeat (25) begin
            @(negedge Clk);
            if (busy) bc++;
            if (frame_done) fc++;
        end
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        model_frame(dy_of(dd));
    endtask

    task automatic test_reset();
        int x, y;
        @(negedge Clk);
        Reset = 1'b1;
        frame_clk = 1'b0;
        rd_idx = 4'd3;
        repeat (2) @(negedge Clk);
        checks++;
        if (rd_x !== 10'd0 || rd_y !== 10'd0 || busy !== 1'b0 || frame_done !== 1'b0 ||
            score !== 16'd0 || overrun !== 1'b0 || scroll_dy !== 4'd0) begin
            failures++;
            $display("FAIL reset_outputs: rd_x=%0d rd_y=%0d busy=%b fd=%b score=%0d ovr=%b dy=%0d, required all zero",
                     rd_x, rd_y, busy, frame_done, score, overrun, scroll_dy);
        end
        Reset = 1'b0;
        model_reset();
        @(negedge Clk);
        checks++;
        if (rd_x !== 10'd160 || rd_y !== 10'd96) begin
            failures++;
            $display("FAIL reset_read3: x=%0d y=%0d, required x=160 y=96", rd_x, rd_y);
        end
        read_slot(15, x, y);
        checks++;
        if (x !== 0 || y !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_read15: x=%0d y=%0d busy=%b, required 0 0 0", x, y, busy);
        end
    endtask

    task automatic test_no_scroll();
        int bc, fc, x, y;
        do_reset();
        run_frame(300, bc, fc);
        checks++;
        if (bc !== 2 || fc !== 1 || scroll_dy !== 4'd0 || score !== 16'd0) begin
            failures++;
            $display("FAIL no_scroll: busy_cycles=%0d done=%0d dy=%0d score=%0d, required 2 1 0 0",
                     bc, fc, scroll_dy, score);
        end
        for (int i = 0; i < 15; i++) begin
            read_slot(i, x, y);
            checks++;
            if (x !== 64 + 32 * i || y !== 32 * i) begin
                failures++;
                $display("FAIL no_scroll_slot%0d: x=%0d y=%0d, required x=%0d y=%0d", i, x, y, 64 + 32 * i, 32 * i);
            end
        end
    endtask

    task automatic test_scroll10();
        int bc, fc, x, y;
        do_reset();
        run_frame(190, bc, fc);
        checks++;
        if (bc !== 17 || fc !== 1 || scroll_dy !== 4'd10 || score !== 16'd10) begin
            failures++;
            $display("FAIL scroll10: busy_cycles=%0d done=%0d dy=%0d score=%0d, required 17 1 10 10",
                     bc, fc, scroll_dy, score);
        end
        read_slot(0, x, y);
        checks++;
        if (x !== 64 || y !== 10) begin
            failures++;
            $display("FAIL scroll10_slot0: x=%0d y=%0d, required x=64 y=10", x, y);
        end
        read_slot(14, x, y);
        checks++;
        if (x !== 512 || y !== 458) begin
            failures++;
            $display("FAIL scroll10_slot14: x=%0d y=%0d, required x=512 y=458", x, y);
        end
    endtask

    task automatic test_clamp_recycle();
        int bc, fc, x, y;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            run_frame(50, bc, fc);
            checks++;
            if (scroll_dy !== 4'd15 || bc !== 17 || fc !== 1) begin
                failures++;
                $display("FAIL clamp_frame%0d: dy=%0d busy_cycles=%0d done=%0d, required 15 17 1", f, scroll_dy, bc, fc);
            end
        end
        read_slot(14, x, y);
        checks++;
        if (x !== 225 || y !== 13 || x !== mx[14]) begin
            failures++;
            $display("FAIL clamp_slot14: x=%0d y=%0d, required x=225 (model %0d) y=13", x, y, mx[14]);
        end
        read_slot(13, x, y);
        checks++;
        if (x !== 480 || y !== 461) begin
            failures++;
            $display("FAIL clamp_slot13: x=%0d y=%0d, required x=480 y=461", x, y);
        end
        checks++;
        if (score !== 16'd45) begin
            failures++;
            $display("FAIL clamp_score: score=%0d, required 45", score);
        end
        // Keep scrolling so several slots wrap and the LFSR walks further.
        repeat (8) run_frame(20, bc, fc);
        for (int i = 0; i < 15; i++) begin
            read_slot(i, x, y);
            checks++;
            if (x !== mx[i] || y !== my[i]) begin
                failures++;
                $display("FAIL multi_wrap_slot%0d: x=%0d y=%0d, required x=%0d y=%0d", i, x, y, mx[i], my[i]);
            end
        end
        checks++;
        if (score !== 16'(m_score)) begin
            failures++;
            $display("FAIL multi_wrap_score: score=%0d, required %0d", score, m_score);
        end
    endtask

    task automatic test_overrun();
        int bc, fc;
        do_reset();
        doodle_y = 10'd190;
        frame_clk = 1'b1;
        bc = 0;
        fc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk);
            if (busy) bc++;
            if (frame_done) fc++;
            if (c == 6) begin
                checks++;
                if (overrun !== 1'b0) begin
                    failures++;
                    $display("FAIL overrun_early: overrun=%b, required 0", overrun);
                end
            end
            if (c == 7) frame_clk = 1'b0;
            if (c == 9) frame_clk = 1'b1;
        end
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        model_frame(10);
        checks++;
        if (bc !== 17 || fc !== 1 || overrun !== 1'b1 || score !== 16'd10) begin
            failures++;
            $display("FAIL overrun_seq: busy_cycles=%0d done=%0d ovr=%b score=%0d, required 17 1 1 10",
                     bc, fc, overrun, score);
        end
        run_frame(195, bc, fc);
        checks++;
        if (bc !== 17 || fc !== 1 || overrun !== 1'b1 || score !== 16'd15) begin
            failures++;
            $display("FAIL overrun_sticky: busy_cycles=%0d done=%0d ovr=%b score=%0d, required 17 1 1 15",
                     bc, fc, overrun, score);
        end
    endtask

    task automatic test_reset_mid_update();
        int bc, fc, x, y, waited;
        do_reset();
        repeat (3) run_frame(50, bc, fc);
        doodle_y = 10'd190;
        frame_clk = 1'b1;
        waited = 0;
        while (!busy && waited < 10) begin
            @(negedge Clk);
            waited++;
        end
        checks++;
        if (!busy) begin
            failures++;
            $display("FAIL mid_reset_start: busy=%b after %0d cycles, required 1", busy, waited);
        end
        repeat (8) @(negedge Clk);
        Reset = 1'b1;
        frame_clk = 1'b0;
        @(negedge Clk);
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || score !== 16'd0 || scroll_dy !== 4'd0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_state: busy=%b fd=%b score=%0d dy=%0d ovr=%b, required all zero",
                     busy, frame_done, score, scroll_dy, overrun);
        end
        Reset = 1'b0;
        model_reset();
        for (int i = 0; i < 15; i++) begin
            read_slot(i, x, y);
            checks++;
            if (x !== 64 + 32 * i || y !== 32 * i) begin
                failures++;
                $display("FAIL mid_reset_slot%0d: x=%0d y=%0d, required x=%0d y=%0d", i, x, y, 64 + 32 * i, 32 * i);
            end
        end
        repeat (3) run_frame(50, bc, fc);
        read_slot(14, x, y);
        checks++;
        if (x !== 225 || y !== 13) begin
            failures++;
            $display("FAIL mid_reset_lfsr: slot14 x=%0d y=%0d, required x=225 y=13", x, y);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_no_scroll();
        test_scroll10();
        test_clamp_recycle();
        test_overrun();
        test_reset_mid_update();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/platform_scroll_sched.md
Name: platform_scroll_sched

Overview:
- Once per video frame, scrolls the 15-slot platform table downward when the doodle climbs above the scroll line.
- Recycles platforms that fall off the bottom back to the top at a pseudo-random X, and accumulates a height score.
- Sits between jumplogic, which supplies the doodle Y and consumes the scroll amount, and color_mapper, which reads platform positions through a registered read port.
- Sequences the update one slot per cycle, so a single adder/comparator datapath is shared across all slots.

Parameters:
NUM_PLAT, 15, number of platform slots (index width 4)
SCREEN_H, 480, visible lines; Y at or beyond this wraps to the top
SCROLL_LINE, 200, doodle Y threshold that triggers scrolling
MAX_SCROLL, 15, per-frame scroll clamp (fits scroll_dy)
LFSR_SEED, 16'hACE1, reset value of the X-placement LFSR

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  synchronous, active-high reset
frame_clk  in  1  VGA vertical sync, asynchronous to this block's logic
doodle_y  in  10  current doodle top Y, sampled in CALC
rd_idx  in  4  platform index for render read
rd_x  out  10  X of slot rd_idx, registered
rd_y  out  10  Y of slot rd_idx, registered
scroll_dy  out  4  scroll applied in the current or last frame
busy  out  1  high while an update sequence runs
frame_done  out  1  one-cycle pulse when an update completes
score  out  16  accumulated scroll distance, saturating
overrun  out  1  sticky flag: a frame trigger arrived while busy

Behaviour:
- Clock and reset: everything runs on Clk. Reset is synchronous and active-high.
- Reset values:
  - State IDLE; busy 0, frame_done 0, scroll_dy 0, score 0, overrun 0, rd_x 0, rd_y 0.
  - LFSR = LFSR_SEED.
  - Slot i: X = 64 + 32*i, Y = 32*i.
  - Reset asserted in any state, including mid-UPDATE, restores all of these on the next edge.
- Trigger:
  - frame_clk passes through a 2-FF synchronizer.
  - A rising edge of the synchronized signal produces a 1-cycle trig.
- FSM:
  - IDLE: on trig, go to CALC.
  - CALC:
    - dy = min(SCROLL_LINE - doodle_y, MAX_SCROLL) if doodle_y < SCROLL_LINE, else 0.
    - Register dy into scroll_dy and clear the slot index.
    - Go to UPDATE if dy != 0, else go to DONE.
  - UPDATE: one slot per cycle, idx 0..NUM_PLAT-1.
    - ny = Y[idx] + dy, computed in 11 bits.
    - If ny >= SCREEN_H: Y = ny - SCREEN_H, X = {1'b0, LFSR[8:0]} (0..511), and the LFSR steps once.
    - Otherwise Y = ny and X is unchanged.
    - After idx NUM_PLAT-1, go to DONE.
  - DONE: frame_done = 1 for this cycle; score = min(score + scroll_dy, 16'hFFFF); go to IDLE.
- busy is high in CALC, UPDATE and DONE.
  - Sequence length: 2 cycles when dy = 0, NUM_PLAT+2 = 17 cycles otherwise.
- LFSR: 16-bit Galois, right-shifting, taps 16'hB400; it steps only on a recycle.
- Trigger while busy: the trigger is dropped, the sequence in progress is unaffected, and overrun is set. overrun clears only on Reset.
- Read port:
  - rd_x/rd_y reflect the table at rd_idx one cycle after rd_idx is presented.
  - rd_idx >= NUM_PLAT returns 0/0.
  - Reads during UPDATE return the current stored value (a mixed frame is acceptable, since the update completes within vertical blank).
- scroll_dy holds its value until the next CALC.

Test Plan:
- Reset, then rd_idx=3 -> rd_x=160, rd_y=96 on the next cycle; busy=0, score=0, overrun=0. Also rd_idx=15 -> rd_x=0, rd_y=0.
- doodle_y=300, one frame_clk rising edge -> scroll_dy=0; busy high exactly 2 cycles; frame_done pulses once; all slots unchanged; score=0.
- doodle_y=190, one frame edge -> scroll_dy=10; busy for 17 cycles; slot0 Y=10, slot14 Y=458; score=10.
- doodle_y=50 for three frames from reset -> scroll_dy=15 each frame (clamped). After frame 3, slot14 Y has wrapped, 448+45=493 -> 13, and X = {0, LFSR[8:0]} matching a reference LFSR model from seed 16'hACE1. Slot13 (Y 416 -> 461) is not recycled. score=45.
- Second frame edge injected 5 cycles into a 17-cycle sequence -> sequence completes normally; exactly one frame_done; overrun=1 and stays 1 after the next normal frame.
- Reset asserted during UPDATE at idx 7 -> next cycle busy=0, state IDLE, slot positions and LFSR at reset values, score=0.
